pll_usb_reset_ctrl: RTL and testbench



---
 rtl/pll_usb_pkg.sv | 19 +
 rtl/pll_usb_reset_ctrl_sync.sv | 24 ++
 rtl/pll_usb_reset_ctrl.sv | 150 +++++++++++++++
 tb/tb_pll_usb_reset_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_usb_pkg.sv
// pll_usb_pkg: shared types and constants for the USB PLL
// reset controller.
package pll_usb_pkg;

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_HOLDOFF   = 2'd1,
        S_RUN       = 2'd2
    } state_t;

    localparam int EDGES_NOM  = 120;
    localparam int WINDOW_DEF = 1000;

    // Width that holds 0..n-1, never below one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_usb_reset_ctrl_sync.sv
// sync_ff: STAGES-deep single-bit synchronizer, async reset to 0.
// Used for both the PLL lock flag and the monitored clock.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_usb_reset_ctrl.sv
// pll_usb_reset_ctrl: lock-filtered reset sequencer plus a
// windowed edge-count monitor on the 12 MHz PLL output.
module pll_usb_reset_ctrl
    import pll_usb_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 16,
    parameter int HOLDOFF     = 1024,
    parameter int WINDOW      = WINDOW_DEF,
    parameter int EDGES_MIN   = EDGES_NOM - 5,
    parameter int EDGES_MAX   = EDGES_NOM + 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       clk_mon,
    input  logic       clear_flags,
    output logic       rst_out,
    output logic       ready,
    output logic       lock_lost,
    output logic       freq_fault,
    output logic [7:0] edge_count
);

    localparam int FW = cnt_w(LOCK_FILTER);
    localparam int HW = cnt_w(HOLDOFF);
    localparam int WW = cnt_w(WINDOW);

    localparam logic [FW-1:0] F_LAST = FW'(LOCK_FILTER - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLDOFF - 1);
    localparam logic [WW-1:0] W_LAST = WW'(WINDOW - 1);

    state_t        state_q;
    logic [FW-1:0] fcnt_q;
    logic [HW-1:0] hcnt_q;
    logic [WW-1:0] wcnt_q;
    logic [7:0]    ecnt_q;
    logic [7:0]    ecnt_d;
    logic          mon_dly_q;
    logic          rst_out_q;
    logic          ready_q;
    logic          lock_lost_q;
    logic          freq_fault_q;
    logic [7:0]    edge_count_q;
    logic          lk_s;
    logic          mon_s;
    logic          mon_rise;
    logic          win_bad;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .clk (clk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (lk_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_mon (
        .clk (clk),
        .rst (rst),
        .d_i (clk_mon),
        .q_o (mon_s)
    );

    assign mon_rise = mon_s & ~mon_dly_q;
    assign ecnt_d   = (ecnt_q == 8'hFF) ? 8'hFF
                                        : ecnt_q + {7'd0, mon_rise};
    assign win_bad  = (int'(ecnt_d) < EDGES_MIN) ||
                      (int'(ecnt_d) > EDGES_MAX);

    // Flag clears are issued first so a same-cycle set overrides them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_WAIT_LOCK;
            fcnt_q       <= '0;
            hcnt_q       <= '0;
            wcnt_q       <= '0;
            ecnt_q       <= '0;
            mon_dly_q    <= 1'b0;
            rst_out_q    <= 1'b1;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
            freq_fault_q <= 1'b0;
            edge_count_q <= '0;
        end else begin
            mon_dly_q <= mon_s;
            if (clear_flags) begin
                lock_lost_q  <= 1'b0;
                freq_fault_q <= 1'b0;
            end
            unique case (state_q)
                S_WAIT_LOCK: begin
                    if (!lk_s) begin
                        fcnt_q <= '0;
                    end else if (fcnt_q == F_LAST) begin
                        state_q <= S_HOLDOFF;
                        fcnt_q  <= '0;
                        hcnt_q  <= '0;
                    end else begin
                        fcnt_q <= fcnt_q + FW'(1);
                    end
                end
                S_HOLDOFF: begin
                    if (!lk_s) begin
                        state_q <= S_WAIT_LOCK;
                        fcnt_q  <= '0;
                    end else if (hcnt_q == H_LAST) begin
                        state_q   <= S_RUN;
                        rst_out_q <= 1'b0;
                        ready_q   <= 1'b1;
                        wcnt_q    <= '0;
                        ecnt_q    <= '0;
                    end else begin
                        hcnt_q <= hcnt_q + HW'(1);
                    end
                end
                S_RUN: begin
                    if (!lk_s) begin
                        state_q     <= S_WAIT_LOCK;
                        fcnt_q      <= '0;
                        rst_out_q   <= 1'b1;
                        ready_q     <= 1'b0;
                        lock_lost_q <= 1'b1;
                    end else if (wcnt_q == W_LAST) begin
                        wcnt_q       <= '0;
                        ecnt_q       <= '0;
                        edge_count_q <= ecnt_d;
                        if (win_bad) begin
                            freq_fault_q <= 1'b1;
                        end
                    end else begin
                        wcnt_q <= wcnt_q + WW'(1);
                        ecnt_q <= ecnt_d;
                    end
                end
                default: begin
                    state_q   <= S_WAIT_LOCK;
                    rst_out_q <= 1'b1;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rst_out    = rst_out_q;
    assign ready      = ready_q;
    assign lock_lost  = lock_lost_q;
    assign freq_fault = freq_fault_q;
    assign edge_count = edge_count_q;

endmodule

// File: tb/tb_pll_usb_reset_ctrl.sv
// tb_pll_usb_reset_ctrl: default-parameter instance for lock latency
// and saturation, small-parameter instance for filtering and windows.
module tb_pll_usb_reset_ctrl;

    localparam int WB   = 100;
    localparam int HMAX = 16384;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    logic       rst_a, lk_a, mon_a, clr_a;
    logic       rso_a, rdy_a, ll_a, ff_a;
    logic [7:0] ec_a;
    logic       rst_b, lk_b, mon_b, clr_b;
    logic       rso_b, rdy_b, ll_b, ff_b;
    logic [7:0] ec_b;

    pll_usb_reset_ctrl dut_a (
        .clk         (clk),
        .rst         (rst_a),
        .pll_locked  (lk_a),
        .clk_mon     (mon_a),
        .clear_flags (clr_a),
        .rst_out     (rso_a),
        .ready       (rdy_a),
        .lock_lost   (ll_a),
        .freq_fault  (ff_a),
        .edge_count  (ec_a)
    );

    pll_usb_reset_ctrl #(
        .LOCK_FILTER (4),
        .HOLDOFF     (8),
        .WINDOW      (WB),
        .EDGES_MIN   (11),
        .EDGES_MAX   (13)
    ) dut_b (
        .clk         (clk),
        .rst         (rst_b),
        .pll_locked  (lk_b),
        .clk_mon     (mon_b),
        .clear_flags (clr_b),
        .rst_out     (rso_b),
        .ready       (rdy_b),
        .lock_lost   (ll_b),
        .freq_fault  (ff_b),
        .edge_count  (ec_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        if (cyc > t) begin
            n_bad++;
            $display("FAIL sched: at cycle %0d past target %0d", cyc, t);
        end
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stimulus generator: phase accumulator of `step` rises per 100
    // cycles, step 0 parks the waveform low, rnd gives random bits.
    int acc  = 0;
    int step = 12;
    bit rnd  = 1'b0;
    bit tog_a = 1'b0;
    bit hist [0:HMAX-1];

    initial begin
        mon_a = 1'b0;
        mon_b = 1'b0;
        forever begin
            @(negedge clk);
            mon_a = tog_a ? ~mon_a : 1'b0;
            if (rnd) begin
                mon_b = 1'($urandom_range(1, 0));
            end else begin
                if (step == 0) acc = 50;
                else acc = (acc + step) % 100;
                mon_b = (acc < 50);
            end
            if (cyc + 1 < HMAX) hist[cyc + 1] = mon_b;
        end
    end

    // Rising edges of the driven waveform as seen after the input
    // synchronizer, over the window reported at edge s+WB.
    function automatic int model_cnt(input int s);
        int n = 0;
        for (int e = s + 1; e <= s + WB; e++) begin
            if (hist[e - 2] && !hist[e - 3]) n++;
        end
        return (n > 255) ? 255 : n;
    endfunction

    task automatic win(input int s, input int nstp, input bit nr,
                       input bit clr);
        wait_until(s + WB - 2);
        step = nstp;
        rnd  = nr;
        wait_until(s + WB - 1);
        clr_b = clr;
        wait_until(s + WB);
        clr_b = 1'b0;
    endtask

    typedef struct {
        int stp;
        bit clr;
        int ec;
        bit ff;
    } vec_t;

    vec_t tv [9];
    int   rstp [10];
    bit   rr [10];
    bit   rclr [10];

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, l, ra, rb, d, s, ns, exp_c;
        bit nr, ff_m;

        tv[0] = '{12, 1'b0, 12, 1'b0};
        tv[1] = '{13, 1'b0, 13, 1'b0};
        tv[2] = '{11, 1'b0, 11, 1'b0};
        tv[3] = '{10, 1'b0, 10, 1'b1};
        tv[4] = '{12, 1'b0, 12, 1'b1};
        tv[5] = '{12, 1'b1, 12, 1'b0};
        tv[6] = '{ 0, 1'b0,  0, 1'b1};
        tv[7] = '{14, 1'b1, 14, 1'b1};
        tv[8] = '{12, 1'b0, 12, 1'b1};
        for (int i = 0; i < 10; i++) begin
            rstp[i] = int'($urandom_range(20, 0));
            rr[i]   = ($urandom_range(2, 0) == 0);
            rclr[i] = ($urandom_range(3, 0) == 0);
        end

        rst_a = 1'b1; lk_a = 1'b0; clr_a = 1'b0;
        rst_b = 1'b1; lk_b = 1'b0; clr_b = 1'b0;
        wait_until(5);
        chk("a_rst_rso", rso_a, 1);
        chk("a_rst_rdy", rdy_a, 0);
        chk("a_rst_ll", ll_a, 0);
        chk("a_rst_ff", ff_a, 0);
        chk("a_rst_ec", ec_a, 0);
        chk("b_rst_rso", rso_b, 1);

        rst_a = 1'b0;
        lk_a  = 1'b1;
        l = cyc + 1;
        wait_until(l + 1040);
        chk("a_lock_hold_rso", rso_a, 1);
        chk("a_lock_hold_rdy", rdy_a, 0);
        wait_until(l + 1041);
        chk("a_lock_fall_rso", rso_a, 0);
        chk("a_lock_rdy", rdy_a, 1);
        chk("a_lock_ll", ll_a, 0);
        chk("a_lock_ff", ff_a, 0);
        ra = l + 1041;
        tog_a = 1'b1;
        wait_until(ra + 999);
        chk("a_win_pending_ec", ec_a, 0);
        wait_until(ra + 1000);
        chk("a_sat_ec", ec_a, 255);
        chk("a_sat_ff", ff_a, 1);
        tog_a = 1'b0;

        lk_a = 1'b0;
        d = cyc + 1;
        wait_until(d + 1);
        chk("a_drop_early_rso", rso_a, 0);
        chk("a_drop_early_ll", ll_a, 0);
        wait_until(d + 2);
        chk("a_drop_rso", rso_a, 1);
        chk("a_drop_rdy", rdy_a, 0);
        chk("a_drop_ll", ll_a, 1);
        wait_until(d + 5);
        chk("a_ll_sticky", ll_a, 1);
        clr_a = 1'b1;
        wait_until(d + 6);
        clr_a = 1'b0;
        chk("a_clr_ll", ll_a, 0);
        chk("a_clr_ff", ff_a, 0);

        lk_a = 1'b1;
        l = cyc + 1;
        wait_until(l + 1040);
        chk("a_relock_hold_rso", rso_a, 1);
        wait_until(l + 1041);
        chk("a_relock_rso", rso_a, 0);
        chk("a_relock_rdy", rdy_a, 1);
        chk("a_relock_ll", ll_a, 0);
        rst_a = 1'b1;

        rst_b = 1'b0;
        lk_b  = 1'b1;
        l0 = cyc + 1;
        wait_until(l0 + 2);
        lk_b = 1'b0;
        wait_until(l0 + 3);
        lk_b = 1'b1;
        l = l0 + 4;
        wait_until(l + 12);
        chk("b_glitch_hold_rso", rso_b, 1);
        chk("b_glitch_hold_rdy", rdy_b, 0);
        wait_until(l + 13);
        chk("b_glitch_fall_rso", rso_b, 0);
        chk("b_glitch_rdy", rdy_b, 1);
        rb = l + 13;

        for (int j = 0; j < 9; j++) begin
            s  = rb + j * WB;
            ns = (j < 8) ? tv[j + 1].stp : rstp[0];
            nr = (j < 8) ? 1'b0 : rr[0];
            win(s, ns, nr, tv[j].clr);
            chk($sformatf("tbl%0d_ec", j), ec_b, tv[j].ec);
            chk($sformatf("tbl%0d_ff", j), ff_b, tv[j].ff);
        end

        ff_m = tv[8].ff;
        for (int i = 0; i < 10; i++) begin
            s  = rb + (9 + i) * WB;
            ns = (i < 9) ? rstp[i + 1] : 12;
            nr = (i < 9) ? rr[i + 1] : 1'b0;
            win(s, ns, nr, rclr[i]);
            exp_c = model_cnt(s);
            if (exp_c < 11 || exp_c > 13) ff_m = 1'b1;
            else if (rclr[i]) ff_m = 1'b0;
            chk($sformatf("rnd%0d_ec", i), ec_b, exp_c);
            chk($sformatf("rnd%0d_ff", i), ff_b, ff_m);
            chk($sformatf("rnd%0d_rdy", i), rdy_b, 1);
        end

        s = rb + 19 * WB;
        wait_until(s + 50);
        rst_b = 1'b1;
        #1;
        chk("b_rstwin_rso", rso_b, 1);
        chk("b_rstwin_rdy", rdy_b, 0);
        chk("b_rstwin_ll", ll_b, 0);
        chk("b_rstwin_ff", ff_b, 0);
        chk("b_rstwin_ec", ec_b, 0);
        wait_until(cyc + 3);
        rst_b = 1'b0;
        l = cyc + 1;
        wait_until(l + 8);
        chk("b_holdoff_rso", rso_b, 1);
        rst_b = 1'b1;
        #1;
        chk("b_rsthold_rso", rso_b, 1);
        chk("b_rsthold_rdy", rdy_b, 0);
        chk("b_rsthold_ec", ec_b, 0);
        wait_until(cyc + 2);
        rst_b = 1'b0;
        l = cyc + 1;
        wait_until(l + 12);
        chk("b_final_hold_rso", rso_b, 1);
        wait_until(l + 13);
        chk("b_final_rso", rso_b, 0);
        chk("b_final_rdy", rdy_b, 1);
        rb = l + 13;
        wait_until(rb + WB - 1);
        chk("b_final_pending_ec", ec_b, 0);
        wait_until(rb + WB);
        chk("b_final_ec", ec_b, 12);
        chk("b_final_ff", ff_b, 0);
        chk("b_final_ll", ll_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
